// File: rtl/ddr_pkg.sv
// Shared DDR controller definitions: geometry constants, burst size encoding
// and a helper that turns a burst size into its beat count.
package ddr_pkg;

  localparam int ADDR_SIZE = 8;
  localparam int DATA_SIZE = 64;
  localparam int MAX_BEATS = 8;

  typedef enum logic [1:0] {
    BL1 = 2'd0,
    BL2 = 2'd1,
    BL4 = 2'd2,
    BL8 = 2'd3
  } burst_size_t;

  // Beat count L of a burst; L-1 is the in-block offset mask.
  function automatic int unsigned burst_len(input burst_size_t bs);
    int unsigned len;
    case (bs)
      BL1:     len = 32'd1;
      BL2:     len = 32'd2;
      BL4:     len = 32'd4;
      BL8:     len = 32'd8;
      default: len = 32'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/raw_data_buffer_unit_beat_index.sv
// Locates a write-pool word inside a read burst: the word hits when it lies in
// the same L-aligned block as the read start, and its beat is its wrapped
// distance from the critical word.
module raw_beat_index
  import ddr_pkg::*;
#(
  parameter int ADDR_SIZE = ddr_pkg::ADDR_SIZE,
  parameter int IDX_W     = 3
) (
  input  logic [ADDR_SIZE-1:0] raddr_pop,
  input  logic [ADDR_SIZE-1:0] pool_waddr,
  input  logic [1:0]           burst_size_pop,
  output logic                 hit,
  output logic [IDX_W-1:0]     idx
);

  logic [ADDR_SIZE-1:0] off_mask_s;
  logic [ADDR_SIZE-1:0] diff_s;

  // Block compare above the offset bits; k-bit wrapping subtraction below.
  always_comb begin
    off_mask_s = ADDR_SIZE'(burst_len(burst_size_t'(burst_size_pop)) - 32'd1);
    diff_s     = pool_waddr - raddr_pop;
    hit        = ((raddr_pop ^ pool_waddr) & ~off_mask_s) == {ADDR_SIZE{1'b0}};
    idx        = diff_s[IDX_W-1:0] & off_mask_s[IDX_W-1:0];
  end

endmodule

// File: rtl/raw_data_buffer_unit.sv
// Read-after-write forwarding buffer: captures write-pool words that overlap a
// popped read into the beat slot they occupy in that read's DDR burst order.
module raw_data_buffer_unit
  import ddr_pkg::*;
#(
  parameter int ADDR_SIZE = ddr_pkg::ADDR_SIZE,
  parameter int DATA_SIZE = ddr_pkg::DATA_SIZE,
  parameter int MAX_BEATS = ddr_pkg::MAX_BEATS
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           raw,
  input  logic [1:0]                     burst_size_pop,
  input  logic [ADDR_SIZE-1:0]           raddr_pop,
  input  logic [ADDR_SIZE-1:0]           pool_waddr,
  input  logic [DATA_SIZE-1:0]           pool_wdata,
  output logic                           raw_valid,
  output logic [MAX_BEATS-1:0]           raw_mask,
  output logic [MAX_BEATS*DATA_SIZE-1:0] raw_data,
  output logic [ADDR_SIZE-1:0]           raw_raddr,
  output logic [1:0]                     raw_burst_size
);

  localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  logic                           hit_s;
  logic [IDX_W-1:0]               idx_s;
  logic                           tag_match_s;
  logic [MAX_BEATS-1:0]           mask_nxt_s;

  logic                           valid_r;
  logic [MAX_BEATS-1:0]           mask_r;
  logic [MAX_BEATS*DATA_SIZE-1:0] data_r;
  logic [ADDR_SIZE-1:0]           raddr_r;
  logic [1:0]                     bsize_r;

  raw_beat_index #(
    .ADDR_SIZE (ADDR_SIZE),
    .IDX_W     (IDX_W)
  ) u_beat_index (
    .raddr_pop      (raddr_pop),
    .pool_waddr     (pool_waddr),
    .burst_size_pop (burst_size_pop),
    .hit            (hit_s),
    .idx            (idx_s)
  );

  // Next mask: keep beats only while the same non-empty burst is being filled.
  always_comb begin
    tag_match_s = (raddr_pop == raddr_r) && (burst_size_pop == bsize_r) &&
                  (mask_r != {MAX_BEATS{1'b0}});
    if (tag_match_s) begin
      mask_nxt_s = mask_r;
    end else begin
      mask_nxt_s = {MAX_BEATS{1'b0}};
    end
    if (hit_s) begin
      mask_nxt_s[idx_s] = 1'b1;
    end else begin
      mask_nxt_s = mask_nxt_s;
    end
  end

  // Tag, mask and beat storage; reset wins over a same-edge capture.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      valid_r <= 1'b0;
      mask_r  <= {MAX_BEATS{1'b0}};
      data_r  <= {(MAX_BEATS*DATA_SIZE){1'b0}};
      raddr_r <= {ADDR_SIZE{1'b0}};
      bsize_r <= 2'd0;
    end else if (raw) begin
      valid_r <= |mask_nxt_s;
      mask_r  <= mask_nxt_s;
      raddr_r <= raddr_pop;
      bsize_r <= burst_size_pop;
      if (hit_s) begin
        data_r[idx_s*DATA_SIZE +: DATA_SIZE] <= pool_wdata;
      end
    end
  end

  assign raw_valid      = valid_r;
  assign raw_mask       = mask_r;
  assign raw_data       = data_r;
  assign raw_raddr      = raddr_r;
  assign raw_burst_size = bsize_r;

endmodule

// File: tb/tb_raw_data_buffer_unit.sv
// Bench for raw_data_buffer_unit: directed cases followed by randomized traffic,
// every cycle checked against an address-arithmetic model of the buffer.
module tb_raw_data_buffer_unit;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         raw;
  logic [1:0]   burst_size_pop;
  logic [7:0]   raddr_pop;
  logic [7:0]   pool_waddr;
  logic [63:0]  pool_wdata;
  logic         raw_valid;
  logic [7:0]   raw_mask;
  logic [511:0] raw_data;
  logic [7:0]   raw_raddr;
  logic [1:0]   raw_burst_size;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  logic [63:0]  m_data [8];
  int           m_mask;
  int           m_raddr;
  int           m_bs;

  raw_data_buffer_unit dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .raw            (raw),
    .burst_size_pop (burst_size_pop),
    .raddr_pop      (raddr_pop),
    .pool_waddr     (pool_waddr),
    .pool_wdata     (pool_wdata),
    .raw_valid      (raw_valid),
    .raw_mask       (raw_mask),
    .raw_data       (raw_data),
    .raw_raddr      (raw_raddr),
    .raw_burst_size (raw_burst_size)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat(input int i);
    return raw_data[i*64 +: 64];
  endfunction

  // Model: burst of L = 2**bs beats wrapping in the L-aligned block.
  task automatic model_update(input logic r_raw, input logic r_nrst, input int bs,
                              input int ra, input int wa, input logic [63:0] d);
    int len;
    int idx;
    if (!r_nrst) begin
      for (int i = 0; i < 8; i++) m_data[i] = 64'd0;
      m_mask = 0; m_raddr = 0; m_bs = 0;
    end else if (r_raw) begin
      len = 1 << bs;
      if (!(ra == m_raddr && bs == m_bs && m_mask != 0)) m_mask = 0;
      m_raddr = ra;
      m_bs = bs;
      if ((wa / len) == (ra / len)) begin
        idx = (wa - ra + 256) % len;
        m_data[idx] = d;
        m_mask = m_mask | (1 << idx);
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [511:0] exp_data;
    for (int i = 0; i < 8; i++) exp_data[i*64 +: 64] = m_data[i];
    chk({tag, "_mask"},  {504'd0, raw_mask}, 512'(m_mask));
    chk({tag, "_valid"}, {511'd0, raw_valid}, 512'(m_mask != 0));
    chk({tag, "_raddr"}, {504'd0, raw_raddr}, 512'(m_raddr));
    chk({tag, "_bsize"}, {510'd0, raw_burst_size}, 512'(m_bs));
    chk({tag, "_data"},  raw_data, exp_data);
  endtask

  task automatic step(input string tag, input logic r_raw, input logic r_nrst,
                      input int bs, input int ra, input int wa, input logic [63:0] d);
    @(negedge clk);
    raw = r_raw; n_rst = r_nrst;
    burst_size_pop = 2'(bs); raddr_pop = 8'(ra); pool_waddr = 8'(wa); pool_wdata = d;
    @(posedge clk);
    model_update(r_raw, r_nrst, bs, ra, wa, d);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [63:0] d;
    int bs, ra, wa, len;
    logic r_raw, r_nrst;

    raw = 1'b0; n_rst = 1'b0; burst_size_pop = 2'd0;
    raddr_pop = 8'd0; pool_waddr = 8'd0; pool_wdata = 64'd0;
    step("rst0", 1'b0, 1'b0, 0, 0, 0, 64'd0);
    step("rst1", 1'b0, 1'b0, 0, 0, 0, 64'd0);
    chk("rst_mask", {504'd0, raw_mask}, 512'd0);
    chk("rst_data", raw_data, 512'd0);

    step("bl1", 1'b1, 1'b1, 0, 8'h9E, 8'h9E, 64'haddb6f04fefee338);
    chk("bl1_mask", {504'd0, raw_mask}, 512'h01);
    chk("bl1_beat0", {448'd0, beat(0)}, {448'd0, 64'haddb6f04fefee338});
    chk("bl1_tag", {502'd0, raw_raddr, raw_burst_size}, {502'd0, 8'h9E, 2'd0});

    step("bl2", 1'b1, 1'b1, 1, 8'hA4, 8'hA4, 64'h659829ff4ebc7f61);
    chk("bl2_beat0", {448'd0, beat(0)}, {448'd0, 64'h659829ff4ebc7f61});
    d = rand64();
    step("bl4", 1'b1, 1'b1, 2, 8'hE1, 8'hE1, d);
    chk("bl4_mask", {504'd0, raw_mask}, 512'h01);
    chk("bl4_beat0", {448'd0, beat(0)}, {448'd0, d});

    step("bl8a", 1'b1, 1'b1, 3, 8'h00, 8'h06, 64'hf38fc74d3141c136);
    chk("bl8a_mask", {504'd0, raw_mask}, 512'h40);
    chk("bl8a_beat6", {448'd0, beat(6)}, {448'd0, 64'hf38fc74d3141c136});
    step("bl8b", 1'b1, 1'b1, 3, 8'hF8, 8'hF9, rand64());
    chk("bl8b_mask", {504'd0, raw_mask}, 512'h02);
    step("bl8c", 1'b1, 1'b1, 3, 8'h05, 8'h00, 64'hf6677c2639c176ef);
    chk("bl8c_mask", {504'd0, raw_mask}, 512'h08);
    chk("bl8c_beat3", {448'd0, beat(3)}, {448'd0, 64'hf6677c2639c176ef});
    step("bl8d", 1'b1, 1'b1, 3, 8'hE7, 8'hE4, rand64());
    chk("bl8d_mask", {504'd0, raw_mask}, 512'h20);
    step("bl8e", 1'b1, 1'b1, 3, 8'hFF, 8'hFF, 64'h0c6ab98ddae5d0e9);
    chk("bl8e_mask", {504'd0, raw_mask}, 512'h01);
    chk("bl8e_beat0", {448'd0, beat(0)}, {448'd0, 64'h0c6ab98ddae5d0e9});

    step("mrg0", 1'b1, 1'b1, 3, 8'h05, 8'h05, rand64());
    step("mrg1", 1'b1, 1'b1, 3, 8'h05, 8'h07, rand64());
    step("mrg2", 1'b1, 1'b1, 3, 8'h05, 8'h00, rand64());
    chk("mrg_mask", {504'd0, raw_mask}, 512'h0D);
    d = rand64();
    step("mrg3", 1'b1, 1'b1, 3, 8'h05, 8'h07, d);
    chk("mrg_ovw", {448'd0, beat(2)}, {448'd0, d});
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b1, 0, 0, 0, rand64());
    chk("idle_mask", {504'd0, raw_mask}, 512'h0D);

    step("miss1", 1'b1, 1'b1, 1, 8'hA4, 8'hA6, rand64());
    chk("miss1_valid", {511'd0, raw_valid}, 512'd0);
    chk("miss1_tag", {502'd0, raw_raddr, raw_burst_size}, {502'd0, 8'hA4, 2'd1});
    step("miss2", 1'b1, 1'b1, 3, 8'h10, 8'h08, rand64());
    chk("miss2_mask", {504'd0, raw_mask}, 512'h00);

    step("fill", 1'b1, 1'b1, 3, 8'h33, 8'h35, rand64());
    step("rstraw", 1'b1, 1'b0, 3, 8'h33, 8'h34, rand64());
    chk("rstraw_all", {raw_data[501:0], raw_mask, raw_raddr, raw_burst_size}, 512'd0);

    // Randomized traffic: often reuse the last tag and the same block to merge.
    ra = 0; bs = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) < 40) begin
        bs = int'($urandom_range(3));
        ra = int'($urandom_range(255));
      end
      len = 1 << bs;
      if ($urandom_range(99) < 75) wa = (ra / len) * len + int'($urandom_range(len - 1));
      else wa = int'($urandom_range(255));
      r_raw  = ($urandom_range(99) < 80);
      r_nrst = ($urandom_range(99) >= 2);
      step("rnd", r_raw, r_nrst, bs, ra, wa, rand64());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
